// File: rtl/taillight_seq_if.sv
// Request and lamp-drive bundle for the turn-signal sequencer.
// The master side raises the requests and the slave side drives the lamps.
interface taillight_seq_if #(
  parameter int LIGHTS = 3
);
  logic                left;
  logic                right;
  logic                hazard;
  logic [2*LIGHTS-1:0] y;
  logic                busy;

  modport master (
    output left,
    output right,
    output hazard,
    input  y,
    input  busy
  );

  modport slave (
    input  left,
    input  right,
    input  hazard,
    output y,
    output busy
  );
endinterface

// File: rtl/taillight_seq.sv
// Sequential turn-signal / hazard lamp controller: lamps grow outward one per
// frame, each non-idle frame lasting TICK_DIV clocks; outputs are Moore-decoded.
module taillight_seq #(
  parameter int LIGHTS   = 3,
  parameter int TICK_DIV = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  taillight_seq_if.slave bus
);

  localparam int            SW       = $clog2(LIGHTS + 1);
  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SW-1:0] STEP_MAX = SW'(LIGHTS);
  localparam logic [SW-1:0] STEP_ONE = SW'(1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEFT_SEQ,
    RIGHT_SEQ,
    HAZ_ON,
    HAZ_OFF
  } state_t;

  state_t          state;
  state_t          state_nxt;
  state_t          entry_state;
  logic [SW-1:0]   step;
  logic [SW-1:0]   step_nxt;
  logic [SW-1:0]   entry_step;
  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_nxt;
  logic            tick;
  logic            eff_haz;
  logic [2*LIGHTS-1:0] y_dec;
  logic            busy_dec;

  // Left group: lamps fill from its lowest bit (innermost) upward.
  function automatic logic [LIGHTS-1:0] grow_up(logic [SW-1:0] n);
    logic [LIGHTS-1:0] m;
    m = '0;
    for (int i = 0; i < LIGHTS; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Right group: lamps fill from its highest bit (innermost) downward.
  function automatic logic [LIGHTS-1:0] grow_down(logic [SW-1:0] n);
    logic [LIGHTS-1:0] m;
    m = '0;
    for (int i = 0; i < LIGHTS; i++) begin
      if (i < int'(n)) m[LIGHTS-1-i] = 1'b1;
    end
    return m;
  endfunction

  assign eff_haz = bus.hazard | (bus.left & bus.right);
  assign tick    = (state != IDLE) && (presc == PRE_MAX);

  // Where a fresh request lands: used from IDLE, after a dark frame and after HAZ_OFF.
  always_comb begin
    entry_state = IDLE;
    entry_step  = '0;
    if (eff_haz) begin
      entry_state = HAZ_ON;
    end else if (bus.left) begin
      entry_state = LEFT_SEQ;
      entry_step  = STEP_ONE;
    end else if (bus.right) begin
      entry_state = RIGHT_SEQ;
      entry_step  = STEP_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    presc_nxt = (state == IDLE || tick) ? '0 : presc + PW'(1);
    case (state)
      IDLE: begin
        state_nxt = entry_state;
        step_nxt  = entry_step;
      end
      LEFT_SEQ, RIGHT_SEQ: begin
        if (tick) begin
          if (eff_haz) begin
            state_nxt = HAZ_ON;
            step_nxt  = '0;
          end else if (step == STEP_MAX) begin
            step_nxt = '0;
          end else if (step != '0) begin
            step_nxt = step + STEP_ONE;
          end else begin
            state_nxt = entry_state;
            step_nxt  = entry_step;
          end
        end
      end
      HAZ_ON: begin
        if (tick) state_nxt = HAZ_OFF;
      end
      HAZ_OFF: begin
        if (tick) begin
          state_nxt = entry_state;
          step_nxt  = entry_step;
        end
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      step  <= '0;
      presc <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      presc <= presc_nxt;
    end
  end

  // Lamp decode depends only on registered state, so reset darkens lamps at once.
  always_comb begin
    y_dec    = '0;
    busy_dec = (state != IDLE);
    case (state)
      LEFT_SEQ:  y_dec[2*LIGHTS-1:LIGHTS] = grow_up(step);
      RIGHT_SEQ: y_dec[LIGHTS-1:0]        = grow_down(step);
      HAZ_ON:    y_dec                    = '1;
      default:   y_dec                    = '0;
    endcase
  end

  assign bus.y    = y_dec;
  assign bus.busy = busy_dec;

endmodule

// File: doc/taillight_seq.md
TAILLIGHT_SEQ -- requirements
Module: taillight_seq

Interface
REQ-001 SHALL have parameter LIGHTS, default 3, lamps per side (legal range 2..8).
REQ-002 SHALL have parameter TICK_DIV, default 4, clock cycles per display frame (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port left  input  1  left turn request, level-sensitive.
REQ-006 SHALL have port right  input  1  right turn request, level-sensitive.
REQ-007 SHALL have port hazard  input  1  hazard request, level-sensitive.
REQ-008 SHALL have port y  output  2*LIGHTS  lamp drive; y[2*LIGHTS-1:LIGHTS] is the left group, y[LIGHTS-1:0] is the right group.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, LEFT_SEQ, RIGHT_SEQ, HAZ_ON and HAZ_OFF, plus a step counter 0..LIGHTS and a frame prescaler 0..TICK_DIV-1.
REQ-011 SHALL decode y and busy as Moore outputs of the registered state and step only, with no combinational path from inputs.
REQ-012 SHALL assert tick when the prescaler equals TICK_DIV-1 and the state is not IDLE; prescaler SHALL wrap to 0 on tick and be held at 0 in IDLE.
REQ-013 SHALL define effective hazard as hazard OR (left AND right).
REQ-014 In IDLE, at each edge: effective hazard -> HAZ_ON; else left -> LEFT_SEQ with step=1; else right -> RIGHT_SEQ with step=1; else remain IDLE. This gives 1-cycle latency from request to first lamp, with no wait for tick.
REQ-015 In LEFT_SEQ, y SHALL light the innermost step lamps of the left group, starting at bit LIGHTS and growing toward bit 2*LIGHTS-1; step=0 is a dark frame with y=0.
REQ-016 In RIGHT_SEQ, y SHALL light the innermost step lamps of the right group, starting at bit LIGHTS-1 and growing toward bit 0; step=0 is a dark frame with y=0.
REQ-017 In LEFT_SEQ/RIGHT_SEQ on tick: effective hazard -> HAZ_ON (preempts immediately); else step<LIGHTS -> step+1; else step==LIGHTS -> step=0 (dark frame).
REQ-018 On tick at a dark frame (step=0): left -> LEFT_SEQ step=1; else right -> RIGHT_SEQ step=1; else IDLE. Releasing or switching direction mid-sequence SHALL NOT truncate the sequence.
REQ-019 HAZ_ON SHALL drive y all ones; on tick it SHALL go to HAZ_OFF.
REQ-020 HAZ_OFF SHALL drive y=0; on tick it SHALL evaluate requests as REQ-014 (IDLE when none), entering the sequence with the prescaler at 0.
REQ-021 Every non-IDLE frame SHALL last exactly TICK_DIV cycles; with TICK_DIV=1, a tick SHALL occur every cycle.
REQ-022 Input changes between ticks, outside IDLE, SHALL have no effect.

Reset
REQ-023 reset_n low SHALL immediately, without waiting for clk, force state=IDLE, step=0, prescaler=0, y=0 and busy=0.
REQ-024 Deassertion of reset_n SHALL take effect at the first rising clk edge after release; a request held through reset SHALL be honoured on that edge per REQ-014.
REQ-025 reset_n asserted mid-sequence SHALL abort the sequence with no further lamp frames.

Verification (LIGHTS=3, TICK_DIV=2)
REQ-026 Hold left from IDLE -> y = 001000, 011000, 111000, 000000 for 2 cycles each, repeating; busy=1 throughout.
REQ-027 Hold right -> y = 000100, 000110, 000111, 000000 for 2 cycles each, repeating.
REQ-028 Pulse left for 1 cycle -> the full 4-frame sequence completes, then IDLE with y=0 and busy=0.
REQ-029 Assert hazard during left frame 011000 -> at the next tick y=111111, then 000000, alternating every 2 cycles; assert left and right together -> same pattern.
REQ-030 Drive reset_n low mid-sequence between clock edges -> y=000000 and busy=0 before the next edge; release with left high -> y=001000 after the first edge.
REQ-031 Re-run REQ-026 with LIGHTS=5, TICK_DIV=1 -> left group grows one lamp per cycle to 11111, then one dark cycle.
